// File: rtl/udp_encoder_buf_if.sv
// Bus bundle for udp_encoder_buf: payload/header inputs from the source, framed words out.
// Carries out_ready only when OUT_READY_EN is defined.
interface udp_encoder_buf_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              data_av;
    logic [DATA_W-1:0] data;
    logic [31:0]       src_ip;
    logic [31:0]       dest_ip;
    logic [15:0]       src_port;
    logic [15:0]       dest_port;
    logic [15:0]       len_in;
    logic              no_chksum;
`ifdef OUT_READY_EN
    logic              out_ready;
`endif
    logic [DATA_W-1:0] pkg_data;
    logic              wr_en;
    logic              fin;
    logic              busy;
    logic              err;

    modport master (
        output start, data_av, data, src_ip, dest_ip, src_port, dest_port, len_in, no_chksum,
`ifdef OUT_READY_EN
        output out_ready,
`endif
        input  pkg_data, wr_en, fin, busy, err
    );

    modport slave (
        input  start, data_av, data, src_ip, dest_ip, src_port, dest_port, len_in, no_chksum,
`ifdef OUT_READY_EN
        input  out_ready,
`endif
        output pkg_data, wr_en, fin, busy, err
    );
endinterface

// File: rtl/udp_encoder_buf.sv
// Buffered UDP encoder: stores the payload, sums the UDP checksum, then emits header + payload.
// Optional OUT_READY_EN adds out_ready backpressure on the output stream.
module udp_encoder_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic             clk,
    input  logic             reset,
    udp_encoder_buf_if.slave bus
);
    localparam int unsigned BYTES     = DATA_W / 8;
    localparam int unsigned HALVES    = BYTES / 2;
    localparam int unsigned LOG2B     = $clog2(BYTES);
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW        = $clog2(DEPTH + 1);
    localparam int unsigned HDR_WORDS = 64 / DATA_W;
    localparam int unsigned MAX_LEN   = DEPTH * BYTES;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SUM  = 3'd2;
    localparam logic [2:0] S_HDR  = 3'd3;
    localparam logic [2:0] S_PAY  = 3'd4;

    logic [2:0]        r_state;
    logic [31:0]       r_src_ip;
    logic [31:0]       r_dest_ip;
    logic [15:0]       r_src_port;
    logic [15:0]       r_dest_port;
    logic [15:0]       r_len;
    logic              r_nochk;
    logic [CW-1:0]     r_nw;
    logic [CW-1:0]     r_cnt;
    logic              r_hidx;
    logic [31:0]       r_acc;
    logic [15:0]       r_chk;
    logic              r_err;
    logic [DATA_W-1:0] r_buf [DEPTH];

    logic              w_idle;
    logic [15:0]       w_len;
    logic [CW-1:0]     w_wcnt;
    logic [16:0]       w_nw17;
    logic [CW-1:0]     w_nw_start;
    logic [CW-1:0]     w_nw;
    logic              w_bad;
    logic              w_start_ok;
    logic              w_accept;
    logic              w_last_in;
    logic [DATA_W-1:0] w_masked;
    logic [31:0]       w_wsum;
    logic [15:0]       w_ulen;
    logic [31:0]       w_sum;
    logic [16:0]       w_f1;
    logic [15:0]       w_f2;
    logic [15:0]       w_chk;
    logic              w_adv;
    logic              w_out;
    logic              w_hdr_last;
    logic              w_pay_last;
    logic [63:0]       w_hdr64;
    logic [63:0]       w_hdr_sh;

    // In IDLE the start-cycle word is judged against the live len_in, not the latched copy
    assign w_idle     = (r_state == S_IDLE);
    assign w_len      = w_idle ? bus.len_in : r_len;
    assign w_wcnt     = w_idle ? '0 : r_cnt;
    assign w_nw17     = ({1'b0, bus.len_in} + 17'(BYTES - 1)) >> LOG2B;
    assign w_nw_start = CW'(w_nw17);
    assign w_nw       = w_idle ? w_nw_start : r_nw;
    assign w_bad      = (32'(bus.len_in) > MAX_LEN) || (bus.len_in > 16'd65527);
    assign w_start_ok = w_idle && bus.start && !w_bad;
    assign w_accept   = bus.data_av && ((w_start_ok && (w_nw_start != '0)) || (r_state == S_LOAD));
    assign w_last_in  = (w_wcnt == CW'(w_nw - 1'b1));

    always_comb begin
        w_masked = bus.data;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (32'(w_wcnt) * BYTES + b >= 32'(w_len))
                w_masked[DATA_W-1-8*b -: 8] = 8'h00;
        end
    end

    always_comb begin
        w_wsum = '0;
        for (int unsigned h = 0; h < HALVES; h++)
            w_wsum = w_wsum + 32'(w_masked[DATA_W-1-16*h -: 16]);
    end

    assign w_ulen = r_len + 16'd8;
    assign w_sum  = r_acc + 32'(r_src_ip[31:16]) + 32'(r_src_ip[15:0])
                  + 32'(r_dest_ip[31:16]) + 32'(r_dest_ip[15:0]) + 32'h0000_0011
                  + 32'(w_ulen) + 32'(w_ulen) + 32'(r_src_port) + 32'(r_dest_port);
    assign w_f1   = 17'(w_sum[31:16]) + 17'(w_sum[15:0]);
    assign w_f2   = 16'(w_f1[16]) + w_f1[15:0];
    assign w_chk  = r_nochk ? 16'h0000 : ((~w_f2 == 16'h0000) ? 16'hFFFF : ~w_f2);

`ifdef OUT_READY_EN
    assign w_adv = bus.out_ready;
`else
    assign w_adv = 1'b1;
`endif

    assign w_out      = (r_state == S_HDR) || (r_state == S_PAY);
    assign w_hdr_last = (r_hidx == 1'(HDR_WORDS - 1));
    assign w_pay_last = (r_cnt == CW'(r_nw - 1'b1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_src_ip    <= '0;
            r_dest_ip   <= '0;
            r_src_port  <= '0;
            r_dest_port <= '0;
            r_len       <= '0;
            r_nochk     <= 1'b0;
            r_nw        <= '0;
            r_cnt       <= '0;
            r_hidx      <= 1'b0;
            r_acc       <= '0;
            r_chk       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_idle && bus.start && w_bad;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_src_ip    <= bus.src_ip;
                        r_dest_ip   <= bus.dest_ip;
                        r_src_port  <= bus.src_port;
                        r_dest_port <= bus.dest_port;
                        r_len       <= bus.len_in;
                        r_nochk     <= bus.no_chksum;
                        r_nw        <= w_nw_start;
                        r_acc       <= w_accept ? w_wsum : '0;
                        r_cnt       <= w_accept ? CW'(1) : '0;
                        if ((w_nw_start == '0) || (w_accept && w_last_in))
                            r_state <= S_SUM;
                        else
                            r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_acc <= r_acc + w_wsum;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last_in)
                            r_state <= S_SUM;
                    end
                end
                S_SUM: begin
                    r_chk   <= w_chk;
                    r_hidx  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_HDR;
                end
                S_HDR: begin
                    if (w_adv) begin
                        if (w_hdr_last)
                            r_state <= (r_nw == '0) ? S_IDLE : S_PAY;
                        else
                            r_hidx <= 1'b1;
                    end
                end
                S_PAY: begin
                    if (w_adv) begin
                        if (w_pay_last)
                            r_state <= S_IDLE;
                        else
                            r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept)
            r_buf[w_wcnt[AW-1:0]] <= w_masked;
    end

    // Header is built as one 64-bit image; 32-bit builds take its halves in turn
    assign w_hdr64  = {r_src_port, r_dest_port, w_ulen, r_chk};
    assign w_hdr_sh = r_hidx ? {w_hdr64[31:0], 32'h0} : w_hdr64;

    always_comb begin
        bus.pkg_data = '0;
        if (r_state == S_HDR)
            bus.pkg_data = w_hdr_sh[63 -: DATA_W];
        else if (r_state == S_PAY)
            bus.pkg_data = r_buf[r_cnt[AW-1:0]];
    end

    assign bus.wr_en = w_out && w_adv;
    assign bus.fin   = w_out && w_adv &&
                       (((r_state == S_HDR) && w_hdr_last && (r_nw == '0)) ||
                        ((r_state == S_PAY) && w_pay_last));
    assign bus.busy  = !w_idle;
    assign bus.err   = r_err;
endmodule

// File: doc/udp_encoder_buf.md
Name: udp_encoder_buf

Overview:
Parametrised successor to the fixed 32-bit UDP encoder. It buffers a payload, computes the UDP checksum over the IPv4 pseudo-header, header and payload, then streams the UDP header followed by the payload. Bus width and buffer depth are generic. Sits between the payload source and the IP encoder / mux in the combined encoder path.

Parameters:
DATA_W, 32, bus width in bits; legal values 32 or 64.
DEPTH, 16, payload buffer depth in DATA_W words; power of 2.
BYTES (derived), DATA_W/8, bytes per word.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  begin packet; sampled in IDLE only.
data_av  in  1  data is valid this cycle.
data  in  DATA_W  payload word, first byte in the MSBs.
src_ip  in  32  pseudo-header source IP.
dest_ip  in  32  pseudo-header destination IP.
src_port  in  16  UDP source port.
dest_port  in  16  UDP destination port.
len_in  in  16  payload length in bytes.
no_chksum  in  1  1 = emit checksum 0x0000.
pkg_data  out  DATA_W  output word.
wr_en  out  1  pkg_data is valid.
fin  out  1  1-cycle pulse coincident with the last wr_en.
busy  out  1  high in every state except IDLE.
err  out  1  1-cycle pulse: packet rejected.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. pkg_data, wr_en, fin, busy, err all 0. Word count and checksum accumulator cleared.
- IDLE, start=1:
  - Latch all header inputs and len_in.
  - NW = ceil(len_in/BYTES).
  - If len_in > DEPTH*BYTES or len_in > 65527: pulse err next cycle, stay IDLE.
  - Else go to LOAD. If NW=0, go to SUM instead.
  - If data_av=1 in the start cycle, that word is word 0 and is accepted.
- LOAD:
  - Each data_av=1 cycle writes the word to buffer[cnt] and adds it to the accumulator as BYTES/2 16-bit words.
  - Bytes at index >= len_in in the last word are zeroed before storing and summing.
  - When the NW-th word is accepted, go to SUM.
  - data_av=0 stalls with no timeout. start is ignored.
- SUM (1 cycle):
  - Add src_ip[31:16], src_ip[15:0], dest_ip[31:16], dest_ip[15:0], 0x0011, ulen twice, src_port, dest_port. ulen = len_in+8.
  - Accumulator is 32 bits. Fold the end-around carry twice, then invert.
  - Result 0x0000 is sent as 0xFFFF. no_chksum=1 forces 0x0000.
- HDR:
  - DATA_W=32: word0 = {src_port,dest_port}, word1 = {ulen,chk}, over 2 cycles.
  - DATA_W=64: single word {src_port,dest_port,ulen,chk}.
- PAY: buffer[0..NW-1] output on consecutive cycles, pad bytes 0.
- Output: wr_en=1 on every HDR/PAY cycle. fin=1 with the final word (the last header word when NW=0). Then return to IDLE.
- Latency: last payload accepted at cycle N → SUM at N+1 → first header word at N+2.
- start while busy=1 is ignored. reset mid-packet aborts immediately with no fin.
- The next start is accepted the cycle after fin.

Optional Feature:
OUT_READY_EN
- Defined: adds input out_ready (1 bit).
  - In HDR/PAY, wr_en = out_ready and the word advances only when out_ready=1.
  - pkg_data holds while out_ready=0.
  - fin is asserted only on the cycle the last word is actually written.
- Undefined: no port. Output advances every cycle as described above.

Test Plan:
- DATA_W=32, "Hello World" (len_in=11), src_ip 9801331b, dest_ip 980e5e4b, ports a08f→2694, data_av 3 consecutive cycles → wr_en 5 cycles. Words: a08f2694, 00132560, 48656c6c, 6f20576f, 726c6400. fin on the 5th.
- Same packet with no_chksum=1 → word1 = 00130000. Same packet at DATA_W=64 → a08f269400132560, 48656c6c6f20576f, 726c640000000000; fin on the 3rd.
- len_in=0 → 2 header words, chk computed over pseudo-header+header only, fin on word1. len_in=DEPTH*4+1 → err pulse, busy stays 0, no wr_en.
- data_av gaps (1,0,0,1,1) during LOAD → same output as the gap-free case. start pulsed during PAY → ignored, no second packet.
- reset driven low during PAY → outputs 0 in the same cycle. Next packet after release is correct.
- OUT_READY_EN with out_ready toggling 1,0,1,0… → words appear only on ready cycles, pkg_data stable while stalled, fin on the last written word.
